// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
//   Shared definitions for the pipeline hazard controller: register-address
//   width, FSM state encodings, the bundle of stall/flush controls and a
//   saturating counter helper.
package hazard_ctrl_pkg;

    localparam int REG_ADDR_LEN = 5;

    // Code 2'd3 is deliberately unused; the FSM treats it as RUN.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_REDIRECT = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
        logic flush_id;
        logic flush_ex;
        logic flush_mem;
    } hz_ctrl_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// load_use_detect
//   Combinational load-use comparator between the load in EX and the
//   source operands of the instruction in ID.
//   in : id_rs_addr, id_rt_addr, id_uses_rt, ex_mem_read_flag, ex_write_reg_addr
//   out: load_use  -- ID must wait one cycle for the load result
module load_use_detect
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_ADDR_LEN-1:0] id_rs_addr,
    input  logic [REG_ADDR_LEN-1:0] id_rt_addr,
    input  logic                    id_uses_rt,
    input  logic                    ex_mem_read_flag,
    input  logic [REG_ADDR_LEN-1:0] ex_write_reg_addr,
    output logic                    load_use
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = (ex_write_reg_addr == id_rs_addr);
    // rt only matters when the ID instruction actually reads it.
    assign rt_hit = id_uses_rt && (ex_write_reg_addr == id_rt_addr);

    // $0 is hard-wired zero, so a load targeting it never produces a hazard.
    assign load_use = ex_mem_read_flag && (ex_write_reg_addr != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard controller. Priority: memory stall > MEM-stage redirect
//   > load-use bubble.
//   in : clk, rst (async, active-high)
//        id_rs_addr, id_rt_addr, id_uses_rt       -- ID operands
//        ex_mem_read_flag, ex_write_reg_addr      -- load in EX
//        mem_redirect                             -- taken branch/jump in MEM
//        mem_req, mem_ready                       -- data memory handshake
//   out: stall_if/id/ex/mem                       -- hold stage registers
//        flush_id/ex/mem                          -- bubble into IF/ID, ID/EX, EX/MEM
//        state, stall_cnt, flush_cnt, mem_timeout -- status
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REG_ADDR_LEN-1:0] id_rs_addr,
    input  logic [REG_ADDR_LEN-1:0] id_rt_addr,
    input  logic                    id_uses_rt,
    input  logic                    ex_mem_read_flag,
    input  logic [REG_ADDR_LEN-1:0] ex_write_reg_addr,
    input  logic                    mem_redirect,
    input  logic                    mem_req,
    input  logic                    mem_ready,
    output logic                    stall_if,
    output logic                    stall_id,
    output logic                    stall_ex,
    output logic                    stall_mem,
    output logic                    flush_id,
    output logic                    flush_ex,
    output logic                    flush_mem,
    output logic [1:0]              state,
    output logic [15:0]             stall_cnt,
    output logic [15:0]             flush_cnt,
    output logic                    mem_timeout
);

    localparam logic [8:0] TMO = 9'(TIMEOUT_CYCLES);

    hz_state_e   state_q, state_d;
    hz_ctrl_t    ctrl;
    logic        load_use;
    logic        mem_hazard;
    logic        redirect_taken;
    logic        any_stall;
    logic [7:0]  wait_cnt;
    logic [15:0] stall_cnt_q, flush_cnt_q;
    logic        timeout_q;

    load_use_detect u_lu (
        .id_rs_addr        (id_rs_addr),
        .id_rt_addr        (id_rt_addr),
        .id_uses_rt        (id_uses_rt),
        .ex_mem_read_flag  (ex_mem_read_flag),
        .ex_write_reg_addr (ex_write_reg_addr),
        .load_use          (load_use)
    );

    assign mem_hazard = mem_req && !mem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d        = ST_RUN;
        ctrl           = '0;
        redirect_taken = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_hazard) begin
                    ctrl.stall_if  = 1'b1;
                    ctrl.stall_id  = 1'b1;
                    ctrl.stall_ex  = 1'b1;
                    ctrl.stall_mem = 1'b1;
                    state_d        = ST_MEM_WAIT;
                end else if (mem_redirect) begin
                    ctrl.flush_id  = 1'b1;
                    ctrl.flush_ex  = 1'b1;
                    ctrl.flush_mem = 1'b1;
                    redirect_taken = 1'b1;
                    state_d        = ST_REDIRECT;
                end else if (load_use) begin
                    // Hold IF/ID, push a bubble into EX; the load moves on.
                    ctrl.stall_if  = 1'b1;
                    ctrl.stall_id  = 1'b1;
                    ctrl.flush_ex  = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                // A redirect held in MEM meanwhile is picked up back in RUN.
                if (!mem_ready) begin
                    ctrl.stall_if  = 1'b1;
                    ctrl.stall_id  = 1'b1;
                    ctrl.stall_ex  = 1'b1;
                    ctrl.stall_mem = 1'b1;
                    state_d        = ST_MEM_WAIT;
                end
            end
            // mem_redirect here is the flushed bubble's flag; ignore it.
            ST_REDIRECT: state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase
    end

    assign any_stall = ctrl.stall_if | ctrl.stall_id | ctrl.stall_ex | ctrl.stall_mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= sat_inc16(stall_cnt_q, any_stall);
            flush_cnt_q <= sat_inc16(flush_cnt_q, redirect_taken);
        end
    end

    // Watchdog: counts MEM_WAIT cycles; the flag is sticky until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (state_q == ST_RUN && state_d == ST_MEM_WAIT) begin
            wait_cnt <= '0;
        end else if (state_q == ST_MEM_WAIT) begin
            if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
            if (({1'b0, wait_cnt} + 9'd1) >= TMO) timeout_q <= 1'b1;
        end
    end

    assign stall_if    = ctrl.stall_if;
    assign stall_id    = ctrl.stall_id;
    assign stall_ex    = ctrl.stall_ex;
    assign stall_mem   = ctrl.stall_mem;
    assign flush_id    = ctrl.flush_id;
    assign flush_ex    = ctrl.flush_ex;
    assign flush_mem   = ctrl.flush_mem;
    assign state       = state_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign mem_timeout = timeout_q;

endmodule
